// File: rtl/led_blinker_pkg.sv
// Shared definitions for the multi-channel LED blinker: channel mode encoding.
package led_blinker_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_PATTERN = 2'd3
    } mode_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: o_tick is high for one cycle while the count sits at DIV-1.
module tick_prescaler #(
    parameter int DIV = 1000
) (
    input  logic i_clock,
    input  logic i_reset_n,
    output logic o_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap to zero after the terminal value.
    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded straight from the count register so channels act on the same edge.
    assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/led_blinker_multi.sv
// Multi-channel LED driver: shared base tick, per-channel OFF/ON/BLINK/PATTERN
// sequencing, configured through a single-cycle write port, globally gated.
module led_blinker_multi
    import led_blinker_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int BASE_DIV = 1000,
    parameter int PER_W    = 8,
    parameter int PAT_W    = 8,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_enable,
    input  logic              i_cfg_valid,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [MODE_W-1:0] i_cfg_mode,
    input  logic [PER_W-1:0]  i_cfg_period,
    input  logic [PAT_W-1:0]  i_cfg_pattern,
    output logic [NUM_CH-1:0] o_led_drive,
    output logic              o_base_tick
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    logic              tick_s;
    logic              ch_ok_s;
    logic [NUM_CH-1:0] drive_d;
    logic [NUM_CH-1:0] drive_q;
    logic              base_tick_q;

    tick_prescaler #(
        .DIV (BASE_DIV)
    ) u_prescaler (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .o_tick    (tick_s)
    );

    // Selects beyond the channel count (possible with a widened select) are dropped.
    assign ch_ok_s = ({1'b0, i_cfg_ch} < (CH_W + 1)'(NUM_CH));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mode_e            mode_q, mode_d;
        logic [PER_W-1:0] per_q, per_d;
        logic [PER_W-1:0] cnt_q, cnt_d;
        logic [PER_W-1:0] last_s;
        logic [PAT_W-1:0] pat_q, pat_d;
        logic [IDX_W-1:0] idx_q, idx_d;
        logic [IDX_W-1:0] idx_inc_s;
        logic             led_q, led_d;
        logic             wr_s;

        assign wr_s      = i_cfg_valid && ch_ok_s && (i_cfg_ch == CH_W'(c));
        assign last_s    = (per_q == {PER_W{1'b0}}) ? {PER_W{1'b0}} : (per_q - PER_W'(1));
        assign idx_inc_s = idx_q + IDX_W'(1);

        // Channel next state; a write in a tick cycle discards that tick here.
        always_comb begin
            mode_d = mode_q;
            per_d  = per_q;
            pat_d  = pat_q;
            cnt_d  = cnt_q;
            idx_d  = idx_q;
            led_d  = led_q;
            if (wr_s) begin
                mode_d = mode_e'(i_cfg_mode);
                per_d  = i_cfg_period;
                pat_d  = i_cfg_pattern;
                cnt_d  = {PER_W{1'b0}};
                idx_d  = {IDX_W{1'b0}};
                case (mode_e'(i_cfg_mode))
                    MODE_OFF:     led_d = 1'b0;
                    MODE_ON:      led_d = 1'b1;
                    MODE_BLINK:   led_d = 1'b1;
                    MODE_PATTERN: led_d = i_cfg_pattern[0];
                    default:      led_d = 1'b0;
                endcase
            end else if (tick_s) begin
                case (mode_q)
                    MODE_OFF: begin
                        led_d = 1'b0;
                        cnt_d = {PER_W{1'b0}};
                        idx_d = {IDX_W{1'b0}};
                    end
                    MODE_ON: begin
                        led_d = 1'b1;
                        cnt_d = {PER_W{1'b0}};
                        idx_d = {IDX_W{1'b0}};
                    end
                    MODE_BLINK: begin
                        if (cnt_q == last_s) begin
                            cnt_d = {PER_W{1'b0}};
                            led_d = ~led_q;
                        end else begin
                            cnt_d = cnt_q + PER_W'(1);
                        end
                    end
                    MODE_PATTERN: begin
                        if (cnt_q == last_s) begin
                            cnt_d = {PER_W{1'b0}};
                            idx_d = idx_inc_s;
                            led_d = pat_q[idx_inc_s];
                        end else begin
                            cnt_d = cnt_q + PER_W'(1);
                        end
                    end
                    default: begin
                        led_d = 1'b0;
                        cnt_d = {PER_W{1'b0}};
                        idx_d = {IDX_W{1'b0}};
                    end
                endcase
            end else begin
                led_d = led_q;
            end
        end

        // Channel state registers.
        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                mode_q <= MODE_OFF;
                per_q  <= PER_W'(1);
                pat_q  <= {PAT_W{1'b0}};
                cnt_q  <= {PER_W{1'b0}};
                idx_q  <= {IDX_W{1'b0}};
                led_q  <= 1'b0;
            end else begin
                mode_q <= mode_d;
                per_q  <= per_d;
                pat_q  <= pat_d;
                cnt_q  <= cnt_d;
                idx_q  <= idx_d;
                led_q  <= led_d;
            end
        end

        assign drive_d[c] = led_d & i_enable;
    end

    // Output registers: drive follows the LED next-state so writes show after one edge.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            drive_q     <= {NUM_CH{1'b0}};
            base_tick_q <= 1'b0;
        end else begin
            drive_q     <= drive_d;
            base_tick_q <= tick_s;
        end
    end

    assign o_led_drive = drive_q;
    assign o_base_tick = base_tick_q;

endmodule

// File: tb/tb_led_blinker_multi.sv
// Directed bench for led_blinker_multi (BASE_DIV=4, 4 channels, 3-bit channel select).
module tb_led_blinker_multi;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       cfg_valid;
    logic [2:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_period;
    logic [7:0] cfg_pattern;
    logic [3:0] led_drive;
    logic       base_tick;

    int n_cmp = 0;
    int n_bad = 0;
    int n     = 0;      // edges since the last reset release
    logic en_at;        // i_enable value seen by the most recent edge

    int         w_e [4];
    int         md  [4];
    int         pr  [4];
    logic [7:0] pt  [4];

    led_blinker_multi #(
        .NUM_CH   (4),
        .BASE_DIV (4),
        .PER_W    (8),
        .PAT_W    (8),
        .CH_W     (3)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_enable      (en),
        .i_cfg_valid   (cfg_valid),
        .i_cfg_ch      (cfg_ch),
        .i_cfg_mode    (cfg_mode),
        .i_cfg_period  (cfg_period),
        .i_cfg_pattern (cfg_pattern),
        .o_led_drive   (led_drive),
        .o_base_tick   (base_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    // Expected LED state at edge e from the channel's last write (ticks at edges 4,8,...).
    function automatic logic led_exp(input int c, input int e);
        int t;
        int eff;
        t   = (e / 4) - (w_e[c] / 4);
        eff = (pr[c] == 0) ? 1 : pr[c];
        case (md[c])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((t / eff) % 2) == 0;
            3:       return pt[c][(t / eff) % 8];
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            w_e[c] = 0; md[c] = 0; pr[c] = 1; pt[c] = 8'h00;
        end
    endtask

    task automatic check_now(input string tag);
        logic [3:0] exp;
        for (int c = 0; c < 4; c++) exp[c] = led_exp(c, n) & en_at;
        chk({tag, "_drive"}, 32'(led_drive), 32'(exp));
        chk({tag, "_tick"}, 32'(base_tick), 32'((n > 0) && (n % 4 == 0)));
    endtask

    task automatic run(input string tag, input int k);
        repeat (k) begin
            en_at = en;
            @(negedge clk);
            n++;
            check_now(tag);
        end
    endtask

    task automatic wr(input string tag, input int ch, input int m, input int p, input logic [7:0] pat);
        cfg_valid   = 1'b1;
        cfg_ch      = 3'(ch);
        cfg_mode    = 2'(m);
        cfg_period  = 8'(p);
        cfg_pattern = pat;
        en_at       = en;
        @(negedge clk);
        n++;
        cfg_valid = 1'b0;
        if (ch < 4) begin
            w_e[ch] = n; md[ch] = m; pr[ch] = p; pt[ch] = pat;
        end
        check_now(tag);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; en_at = 1'b1;
        cfg_valid = 1'b0; cfg_ch = 3'd0; cfg_mode = 2'd0;
        cfg_period = 8'd0; cfg_pattern = 8'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_drive", 32'(led_drive), 32'd0);
        chk("reset_tick", 32'(base_tick), 32'd0);
        rst_n = 1'b1;
        n = 0;

        run("prescale", 8);
        wr("blink_wr", 1, 2, 3, 8'h00);
        run("blink", 40);
        wr("pat_wr", 2, 3, 1, 8'b1011_0010);
        run("pattern", 40);
        wr("per0_wr", 3, 2, 0, 8'h00);
        run("per0", 16);
        wr("on_wr", 3, 1, 5, 8'h00);
        run("on", 20);

        while (n % 4 != 3) run("align", 1);
        wr("coll_wr", 1, 2, 3, 8'h00);
        chk("coll_on_tick", 32'(base_tick), 32'd1);
        run("coll", 30);
        wr("inv_wr", 5, 1, 1, 8'hFF);
        run("inv", 10);

        en = 1'b0;
        run("en_off", 20);
        en = 1'b1;
        run("en_on", 30);

        #2 rst_n = 1'b0;
        #1;
        chk("midrst_drive", 32'(led_drive), 32'd0);
        chk("midrst_tick", 32'(base_tick), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        model_reset();
        run("post_rst", 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
